hamming_7_4_tx: RTL and testbench
=================================

Name: hamming_7_4_tx

Overview:
Transmit-side neighbour of the Hamming(7,4) decoder.
- Accepts a 4-bit data nibble through a valid/ready handshake and encodes it into a 7-bit codeword, cw[7:1].
- Parity bits sit in positions 1, 2 and 4. Data sits in positions 3, 5, 6 and 7.
- Shifts the codeword out serially, cw[1] first, with each bit held BIT_PERIOD clocks.
- Optional single-bit error injection is provided so the lab can exercise the decoder's correction path.

Parameters:
BIT_PERIOD, 1, clock cycles each serial bit is held; legal range is 1..65535.

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst  input  1  synchronous, active-high reset
in_data  input  4  nibble to send; data[3]→cw[3], data[2]→cw[5], data[1]→cw[6], data[0]→cw[7]
in_valid  input  1  in_data, inject_pos valid
in_ready  output  1  block can accept a nibble this cycle
inject_pos  input  3  0 = no injection; 1..7 = invert that codeword bit before sending
sout  output  1  serial codeword bit
sout_valid  output  1  sout carries a codeword bit
sout_first  output  1  high while cw[1] of a codeword is on sout
cw_out  output  7  codeword currently being sent, including any injected error; for loopback into the decoder
word_count  output  8  number of completed codewords, wraps

Behaviour:
Encoding:
- p1 = cw[1] = d3^d2^d0.
- p2 = cw[2] = d3^d1^d0.
- p4 = cw[4] = d2^d1^d0.
- The codeword is XORed with a one-hot mask at inject_pos (no mask when inject_pos = 0).
- Encoding and injection are captured in the accept cycle.

State machine, two states:
- IDLE:
  - sout_valid = 0, sout_first = 0, sout = 0.
  - On accept, load the shift register and cw_out, set bit index to 1 and the divider to 0, then go to SHIFT.
- SHIFT:
  - sout = cw[idx], sout_valid = 1, sout_first = (idx == 1).
  - The divider counts 0..BIT_PERIOD-1. At BIT_PERIOD-1 the divider clears and idx increments.
  - At idx = 7 with divider = BIT_PERIOD-1 (the "last cycle"), word_count increments. The state then goes to IDLE, or reloads if a new nibble is accepted in that same cycle.

Handshake and timing:
- Accept = in_valid & in_ready.
- in_ready is combinational: (state == IDLE | last cycle) & ~rst.
- Latency: an accept in cycle N puts cw[1] on sout in cycle N+1.
  - A codeword occupies exactly 7·BIT_PERIOD cycles.
  - Back-to-back accepts produce a continuous stream with no idle cycle: sout_valid stays high and sout_first pulses at each word start.
- in_data and inject_pos are ignored when not accepted. A change in in_data mid-word has no effect on sout or cw_out.
- in_valid held with in_ready low: no effect. Data need not be held stable by any protocol rule other than at the accept cycle.

Registers and counters:
- sout, sout_valid, sout_first, cw_out and word_count are registers.
- word_count wraps from 255 to 0.
- The divider is wide enough for BIT_PERIOD-1. With BIT_PERIOD = 1, every cycle is a bit boundary.

Reset:
- Values while rst is high: state = IDLE, sout = 0, sout_valid = 0, sout_first = 0, cw_out = 0, word_count = 0, divider = 0, idx = 1, in_ready = 0.
- A reset mid-word aborts that word immediately with no completion count.
- in_ready = 1 in the first cycle after rst falls.

Test Plan:
- BIT_PERIOD=1, reset, then accept 4'b1011 with inject_pos=0 → cw_out = 7'b1100110; sout over 7 cycles = 0,1,1,0,0,1,1; sout_first high only in the first cycle; word_count = 1; in_ready low in bits 1–6.
- Accept 4'b0000, then 4'b1111, held valid back-to-back → the second accept lands on the last cycle of the first word; sout_valid is continuous for 14 cycles; the codewords are 7'b0000000 then 7'b1111111; sout_first pulses at cycles 1 and 8.
- BIT_PERIOD=3, accept 4'b1011 with inject_pos=5 → cw_out = 7'b1110110; each bit is held exactly 3 cycles (21 total). With cw_out looped into the decoder, its data = 4'b1011 and error = 1.
- Assert rst during bit 4 of a word → the next cycle has sout_valid = 0, word_count unchanged, and in_ready = 1 after release. A following accept of 4'b1011 sends a clean 7'b1100110.
- Stream 257 words at BIT_PERIOD=1 → word_count reads 255 after word 255, 0 after word 256, and 1 after word 257.
- Toggle in_data and hold in_valid high mid-word → sout and cw_out stay unchanged; the next accept occurs only on the last cycle of the current word.

Source files
------------

// File: rtl/hamming_7_4_tx.sv
// Hamming(7,4) transmitter: encodes a nibble into cw[7:1] (parity in positions
// 1, 2 and 4), optionally inverts one codeword bit, and shifts the codeword out
// cw[1] first with each bit held BIT_PERIOD clocks.
module hamming_7_4_tx #(
    parameter int unsigned BIT_PERIOD = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] inject_pos,
    output logic       sout,
    output logic       sout_valid,
    output logic       sout_first,
    output logic [6:0] cw_out,
    output logic [7:0] word_count
);

    localparam int unsigned   DW       = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(BIT_PERIOD - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t          state;
    logic [2:0]      idx;
    logic [DW-1:0]   div;
    logic [6:0]      enc_cw;
    logic [6:0]      inj_mask;
    logic [6:0]      new_cw;
    logic            last_cycle;
    logic            accept;

    // Encode the incoming nibble; bit k-1 of each vector holds cw[k].
    always_comb begin
        enc_cw[0] = in_data[3] ^ in_data[2] ^ in_data[0];
        enc_cw[1] = in_data[3] ^ in_data[1] ^ in_data[0];
        enc_cw[2] = in_data[3];
        enc_cw[3] = in_data[2] ^ in_data[1] ^ in_data[0];
        enc_cw[4] = in_data[2];
        enc_cw[5] = in_data[1];
        enc_cw[6] = in_data[0];
        inj_mask  = '0;
        if (inject_pos != 3'd0) begin
            inj_mask = 7'd1 << (inject_pos - 3'd1);
        end
        new_cw = enc_cw ^ inj_mask;
    end

    // Handshake: ready while idle or on the final cycle of the current word.
    always_comb begin
        last_cycle = (state == SHIFT) && (idx == 3'd7) && (div == DIV_LAST);
        in_ready   = ((state == IDLE) || last_cycle) && !rst;
        accept     = in_valid && in_ready;
    end

    // Shift FSM with registered serial outputs. cw_out doubles as the shift
    // source since it always holds the word being sent.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= 3'd1;
            div        <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            sout_first <= 1'b0;
            cw_out     <= '0;
            word_count <= '0;
        end else if (accept) begin
            // Accept is only possible from IDLE or the last cycle, so a reload
            // here also covers back-to-back words.
            if (last_cycle) begin
                word_count <= word_count + 8'd1;
            end
            state      <= SHIFT;
            cw_out     <= new_cw;
            idx        <= 3'd1;
            div        <= '0;
            sout       <= new_cw[0];
            sout_valid <= 1'b1;
            sout_first <= 1'b1;
        end else if (state == SHIFT) begin
            if (div == DIV_LAST) begin
                div <= '0;
                if (idx == 3'd7) begin
                    word_count <= word_count + 8'd1;
                    state      <= IDLE;
                    idx        <= 3'd1;
                    sout       <= 1'b0;
                    sout_valid <= 1'b0;
                    sout_first <= 1'b0;
                end else begin
                    idx        <= idx + 3'd1;
                    sout       <= cw_out[idx];
                    sout_first <= 1'b0;
                end
            end else begin
                div <= div + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hamming_7_4_tx.sv
// Bench for hamming_7_4_tx: lane 0 runs BIT_PERIOD=1, lane 1 runs BIT_PERIOD=3.
// Each lane's scoreboard queues one expected entry per serial cycle on accept.
module tb_hamming_7_4_tx;

    logic       clk;
    logic       rst;
    logic       in_valid   [2];
    logic [3:0] in_data    [2];
    logic [2:0] inject_pos [2];
    logic       in_ready   [2];
    logic       sout       [2];
    logic       sout_valid [2];
    logic       sout_first [2];
    logic [6:0] cw_out     [2];
    logic [7:0] word_count [2];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       bitv;
        logic       first;
        logic       last;
        logic [6:0] cw;
    } ent_t;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Position-based Hamming model: parity p covers every position with bit p set.
    function automatic logic [6:0] model_cw(input logic [3:0] d, input logic [2:0] inj);
        logic [7:1] c;
        logic       x;
        c    = '0;
        c[3] = d[3];
        c[5] = d[2];
        c[6] = d[1];
        c[7] = d[0];
        for (int p = 0; p < 3; p++) begin
            x = 1'b0;
            for (int pos = 1; pos <= 7; pos++)
                if ((pos & (1 << p)) != 0) x ^= c[pos];
            c[1 << p] = x;
        end
        if (inj != 3'd0) c[inj] = ~c[inj];
        return c[7:1];
    endfunction

    // Decoder model: returns {error, data[3:0]}.
    function automatic logic [4:0] model_decode(input logic [6:0] w);
        logic [7:1] c;
        logic [2:0] s;
        c = w;
        s = '0;
        for (int pos = 1; pos <= 7; pos++)
            if (c[pos]) s ^= 3'(pos);
        if (s != 3'd0) c[s] = ~c[s];
        return {s != 3'd0, c[3], c[5], c[6], c[7]};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int unsigned BP = (g == 0) ? 1 : 3;

        hamming_7_4_tx #(.BIT_PERIOD(BP)) dut (
            .clk        (clk),
            .rst        (rst),
            .in_data    (in_data[g]),
            .in_valid   (in_valid[g]),
            .in_ready   (in_ready[g]),
            .inject_pos (inject_pos[g]),
            .sout       (sout[g]),
            .sout_valid (sout_valid[g]),
            .sout_first (sout_first[g]),
            .cw_out     (cw_out[g]),
            .word_count (word_count[g])
        );

        ent_t       q[$];
        ent_t       e;
        logic [6:0] mcw;
        logic       rst_edge = 1'b1;
        logic       pend     = 1'b0;
        int         exp_wc   = 0;
        logic [6:0] exp_cw   = '0;
        logic       ev, es, ef;

        // Push expectations at the accept edge, then compare outputs 1 ns later.
        always @(posedge clk) begin
            if (rst) begin
                q.delete();
                rst_edge = 1'b1;
            end else begin
                rst_edge = 1'b0;
                if (in_valid[g] && in_ready[g]) begin
                    mcw = model_cw(in_data[g], inject_pos[g]);
                    for (int b = 0; b < 7; b++) begin
                        for (int r = 0; r < BP; r++) begin
                            e.bitv  = mcw[b];
                            e.first = (b == 0);
                            e.last  = (b == 6) && (r == BP - 1);
                            e.cw    = mcw;
                            q.push_back(e);
                        end
                    end
                end
            end
            #1;
            if (rst_edge) begin
                exp_wc = 0;
                exp_cw = '0;
                pend   = 1'b0;
            end else if (pend) begin
                exp_wc = (exp_wc + 1) % 256;
                pend   = 1'b0;
            end
            ev = 1'b0;
            es = 1'b0;
            ef = 1'b0;
            if (q.size() != 0) begin
                e  = q.pop_front();
                ev = 1'b1;
                es = e.bitv;
                ef = e.first;
                if (e.first) exp_cw = e.cw;
                if (e.last) pend = 1'b1;
            end
            check($sformatf("L%0d sout_valid", g), sout_valid[g], ev);
            check($sformatf("L%0d sout", g), sout[g], es);
            check($sformatf("L%0d sout_first", g), sout_first[g], ef);
            check($sformatf("L%0d cw_out", g), cw_out[g], exp_cw);
            check($sformatf("L%0d word_count", g), word_count[g], exp_wc);
            check($sformatf("L%0d in_ready", g), in_ready[g], (q.size() == 0) && !rst);
        end
    end

    // Present a nibble and wait (bounded) for its accept edge; returns at the
    // following falling edge, dropping in_valid unless keep is set.
    task automatic send(input int k, input logic [3:0] d, input logic [2:0] inj, input bit keep);
        bit ok;
        ok            = 1'b0;
        in_valid[k]   = 1'b1;
        in_data[k]    = d;
        inject_pos[k] = inj;
        for (int n = 0; n < 1000; n++) begin
            @(posedge clk);
            if (in_ready[k]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("send_timeout", 32'd0, 32'd1);
        @(negedge clk);
        if (!keep) in_valid[k] = 1'b0;
    endtask

    initial begin
        logic [4:0] dec;
        int         n;
        bit         acc;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_valid[k]   = 1'b0;
            in_data[k]    = '0;
            inject_pos[k] = '0;
        end
        repeat (3) @(negedge clk);
        check("reset sout_valid", sout_valid[0], 1'b0);
        check("reset cw_out", cw_out[0], 7'd0);
        check("reset word_count", word_count[0], 8'd0);
        check("reset in_ready", in_ready[0], 1'b0);
        rst = 1'b0;
        #1;
        check("ready after reset", in_ready[0], 1'b1);

        // Single word at BIT_PERIOD=1.
        send(0, 4'b1011, 3'd0, 1'b0);
        check("w1 cw_out", cw_out[0], 7'b1100110);
        check("w1 first", sout_first[0], 1'b1);
        check("w1 sout bit1", sout[0], 1'b0);
        repeat (7) @(negedge clk);
        check("w1 word_count", word_count[0], 8'd1);
        check("w1 idle", sout_valid[0], 1'b0);

        // Back-to-back words.
        send(0, 4'b0000, 3'd0, 1'b1);
        check("b2b cw0", cw_out[0], 7'b0000000);
        send(0, 4'b1111, 3'd0, 1'b0);
        check("b2b cw1", cw_out[0], 7'b1111111);
        check("b2b first", sout_first[0], 1'b1);
        repeat (8) @(negedge clk);
        check("b2b word_count", word_count[0], 8'd3);

        // BIT_PERIOD=3 with injection at position 5, looped into a decoder model.
        send(1, 4'b1011, 3'd5, 1'b0);
        check("inj cw_out", cw_out[1], 7'b1110110);
        dec = model_decode(cw_out[1]);
        check("inj decoded data", dec[3:0], 4'b1011);
        check("inj decoded error", dec[4], 1'b1);
        repeat (22) @(negedge clk);
        check("inj word_count", word_count[1], 8'd1);

        // Reset during bit 4.
        send(0, 4'b0110, 3'd0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst sout_valid", sout_valid[0], 1'b0);
        check("midrst word_count", word_count[0], 8'd0);
        rst = 1'b0;
        #1;
        check("midrst ready", in_ready[0], 1'b1);
        send(0, 4'b1011, 3'd0, 1'b0);
        check("midrst clean cw", cw_out[0], 7'b1100110);
        repeat (8) @(negedge clk);

        // Toggle in_data with in_valid held mid-word.
        send(0, 4'b0110, 3'd0, 1'b1);
        acc = 1'b0;
        for (n = 1; n < 100; n++) begin
            @(posedge clk);
            if (in_ready[0]) acc = 1'b1;
            @(negedge clk);
            if (acc) break;
            in_data[0]    = 4'($urandom_range(0, 15));
            inject_pos[0] = 3'($urandom_range(0, 7));
        end
        in_valid[0] = 1'b0;
        check("toggle accept cycle", n, 7);
        repeat (10) @(negedge clk);

        // word_count wrap.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 255; i++)
            send(0, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), i != 254);
        repeat (10) @(negedge clk);
        check("wrap 255", word_count[0], 8'd255);
        send(0, 4'b1001, 3'd0, 1'b0);
        repeat (10) @(negedge clk);
        check("wrap 256", word_count[0], 8'd0);
        send(0, 4'b0101, 3'd0, 1'b0);
        repeat (10) @(negedge clk);
        check("wrap 257", word_count[0], 8'd1);

        check("L0 drained", lane[0].q.size(), 0);
        check("L1 drained", lane[1].q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
